// File: rtl/router_pkg.sv
// Shared types for the router output-port receiver.
package router_pkg;

  typedef enum logic {RX_IDLE, RX_RECV} rx_state_e;

  localparam int PORT_NUM   = 16;
  localparam int RX_DATA_W  = 8;

  // Default-width FIFO entry; the receiver builds its own at its DATA_W.
  typedef struct packed {
    logic [RX_DATA_W-1:0] data;
    logic                 last;
  } rx_word_t;

endpackage

// File: rtl/router_out_fifo.sv
// Synchronous FIFO with a registered count; head entry reads as zero when empty.
module router_out_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_push,
  input  T     i_wdata,
  input  logic i_pop,
  output T     o_rdata,
  output logic o_valid,
  output logic o_drop
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  T              r_mem [DEPTH];

  logic w_pop, w_full, w_push;

  assign w_pop   = i_pop && (r_cnt != '0);
  assign w_full  = (r_cnt == FULL_CNT);
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_drop  = i_push && w_full && !w_pop;
  assign o_valid = (r_cnt != '0);
  assign o_rdata = o_valid ? r_mem[r_rd] : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= i_wdata;
  end

endmodule

// File: rtl/router_out_deserializer.sv
// Rebuilds LSB-first serial router output into words behind a ready/valid FIFO.
// Optional ROUTER_DESER_PKTCNT_EN adds popped packet/word counters.
module router_out_deserializer
  import router_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              dout,
  input  logic              valido_n,
  input  logic              frameo_n,
  output logic [DATA_W-1:0] pkt_data,
  output logic              pkt_last,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic              rx_busy,
  output logic              frame_err,
  output logic              ovf_err,
`ifdef ROUTER_DESER_PKTCNT_EN
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       word_cnt,
`endif
  input  logic              clr_err
);

  localparam int              CW       = $clog2(DATA_W);
  localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_W-1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } word_t;

  rx_state_e         r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
  logic              r_frame_err, r_ovf_err;

  logic  w_take, w_done, w_ferr_set, w_drop, w_pop;
  word_t w_wdata, w_rdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= RX_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        // The frame-opening cycle may already carry bit 0.
        if (!frameo_n) begin
          w_state_nxt = RX_RECV;
          w_take      = !valido_n;
        end
      end
      RX_RECV: begin
        w_take = !valido_n;
        if (frameo_n) begin
          w_state_nxt = RX_IDLE;
          w_ferr_set  = valido_n ? (r_cnt != '0) : (r_cnt != LAST_BIT);
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  assign w_done = w_take && (r_cnt == LAST_BIT);

  always_comb begin
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    if (w_take) begin
      w_shreg_nxt[r_cnt] = dout;
      w_cnt_nxt          = w_done ? '0 : r_cnt + 1'b1;
    end
    // Leaving a frame always discards any partial word.
    if (w_state_nxt == RX_IDLE) w_cnt_nxt = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_shreg <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  assign w_wdata.data = {dout, r_shreg[DATA_W-2:0]};
  assign w_wdata.last = frameo_n;
  assign w_pop        = pkt_valid && pkt_ready;

  router_out_fifo #(.T(word_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_done),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_valid (pkt_valid),
    .o_drop  (w_drop)
  );

  assign pkt_data = w_rdata.data;
  assign pkt_last = w_rdata.last;
  assign rx_busy  = (r_state == RX_RECV);

  // Set beats clear when both happen in one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_err <= 1'b0;
      r_ovf_err   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr_set | (r_frame_err & ~clr_err);
      r_ovf_err   <= w_drop     | (r_ovf_err   & ~clr_err);
    end
  end

  assign frame_err = r_frame_err;
  assign ovf_err   = r_ovf_err;

`ifdef ROUTER_DESER_PKTCNT_EN
  logic [15:0] r_pkt_cnt, r_word_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pkt_cnt  <= '0;
      r_word_cnt <= '0;
    end else if (clr_err) begin
      r_pkt_cnt  <= '0;
      r_word_cnt <= '0;
    end else if (w_pop) begin
      r_word_cnt <= r_word_cnt + 16'd1;
      if (pkt_last) r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

  assign pkt_cnt  = r_pkt_cnt;
  assign word_cnt = r_word_cnt;
`endif

endmodule

// File: tb/tb_router_out_deserializer.sv
// Directed bench for router_out_deserializer; popped words are logged and compared.
module tb_router_out_deserializer;

  logic       clk, rst_n;
  logic       dout, valido_n, frameo_n, pkt_ready, clr_err;
  logic [7:0] pkt_data;
  logic       pkt_last, pkt_valid, rx_busy, frame_err, ovf_err;
`ifdef ROUTER_DESER_PKTCNT_EN
  logic [15:0] pkt_cnt, word_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] popq[$];

  router_out_deserializer #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clock     (clk),
    .reset_n   (rst_n),
    .dout      (dout),
    .valido_n  (valido_n),
    .frameo_n  (frameo_n),
    .pkt_data  (pkt_data),
    .pkt_last  (pkt_last),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .ovf_err   (ovf_err),
`ifdef ROUTER_DESER_PKTCNT_EN
    .pkt_cnt   (pkt_cnt),
    .word_cnt  (word_cnt),
`endif
    .clr_err   (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record handshakes just before the rising edge, after inputs settle.
  always begin
    @(negedge clk);
    #4;
    if (pkt_valid && pkt_ready) popq.push_back({pkt_last, pkt_data});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic d, input logic v_n, input logic f_n);
    @(negedge clk);
    dout = d; valido_n = v_n; frameo_n = f_n;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b1, 1'b1);
  endtask

  // Sends one byte LSB-first; frameo_n rises with bit 7 when 'fin' is set.
  task automatic send_byte(input logic [7:0] b, input logic fin);
    for (int i = 0; i < 8; i++) drv(b[i], 1'b0, (fin && i == 7));
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
  endtask

  task automatic chk_q(input string tag, input int idx, input logic [8:0] exp);
    logic [8:0] got;
    got = (idx < popq.size()) ? popq[idx] : 9'h1xx;
    chk(tag, {23'd0, got}, {23'd0, exp});
  endtask

  logic [7:0] b;

  initial begin
    rst_n = 1'b0; dout = 1'b0; valido_n = 1'b1; frameo_n = 1'b1;
    pkt_ready = 1'b1; clr_err = 1'b0;
    #23;
    chk("rst_valid", pkt_valid, 1'b0);
    chk("rst_data",  pkt_data,  8'h00);
    chk("rst_last",  pkt_last,  1'b0);
    chk("rst_busy",  rx_busy,   1'b0);
    chk("rst_ferr",  frame_err, 1'b0);
    chk("rst_oerr",  ovf_err,   1'b0);
    rst_n = 1'b1;
    idle(2);

    // Two-byte packet A5, 3C.
    popq.delete();
    b = 8'hA5;
    for (int i = 0; i < 8; i++) drv(b[i], 1'b0, 1'b0);
    chk("t1_vld_pre", pkt_valid, 1'b0);
    b = 8'h3C;
    drv(b[0], 1'b0, 1'b0);
    chk("t1_vld_lat", pkt_valid, 1'b1);
    chk("t1_data_lat", pkt_data, 8'hA5);
    for (int i = 1; i < 8; i++) drv(b[i], 1'b0, (i == 7));
    idle(3);
    chk("t1_nq", popq.size(), 2);
    chk_q("t1_w0", 0, 9'h0A5);
    chk_q("t1_w1", 1, 9'h13C);
    chk("t1_ferr", frame_err, 1'b0);
    chk("t1_busy", rx_busy, 1'b0);

    // Gaps inside byte 81.
    popq.delete();
    b = 8'h81;
    for (int i = 0; i < 4; i++) drv(b[i], 1'b0, 1'b0);
    for (int g = 0; g < 3; g++) begin
      drv(1'b1, 1'b1, 1'b0);
      chk("t2_busy_gap", rx_busy, 1'b1);
    end
    for (int i = 4; i < 8; i++) drv(b[i], 1'b0, (i == 7));
    idle(3);
    chk("t2_nq", popq.size(), 1);
    chk_q("t2_w0", 0, 9'h181);

    // Partial word: 12 bits.
    popq.delete();
    send_byte(8'h96, 1'b0);
    for (int i = 0; i < 4; i++) drv(i[0], 1'b0, (i == 3));
    idle(3);
    chk("t3_nq", popq.size(), 1);
    chk_q("t3_w0", 0, 9'h096);
    chk("t3_ferr", frame_err, 1'b1);
    pulse_clr();
    chk("t3_ferr_clr", frame_err, 1'b0);

    // Overflow: 5 bytes into a 4-deep FIFO with no consumer.
    popq.delete();
    pkt_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_byte(8'h10 + 8'(k), (k == 4));
    idle(2);
    chk("t4_valid", pkt_valid, 1'b1);
    chk("t4_head", pkt_data, 8'h10);
    chk("t4_oerr", ovf_err, 1'b1);
    chk("t4_ferr", frame_err, 1'b0);
    @(negedge clk); pkt_ready = 1'b1;
    idle(6);
    chk("t4_nq", popq.size(), 4);
    for (int k = 0; k < 4; k++) chk_q("t4_w", k, {1'b0, 8'h10 + 8'(k)});
    chk("t4_empty", pkt_valid, 1'b0);
    pulse_clr();
    chk("t4_oerr_clr", ovf_err, 1'b0);

    // Back-to-back single-byte frames.
    popq.delete();
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(3);
    chk("t5_nq", popq.size(), 2);
    chk_q("t5_w0", 0, 9'h1FF);
    chk_q("t5_w1", 1, 9'h100);
    chk("t5_ferr", frame_err, 1'b0);

    // Async reset mid-byte with two words queued.
    popq.delete();
    pkt_ready = 1'b0;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    for (int i = 0; i < 3; i++) drv(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6_valid_pre", pkt_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_valid_rst", pkt_valid, 1'b0);
    chk("t6_busy_rst", rx_busy, 1'b0);
    valido_n = 1'b1; frameo_n = 1'b1;
    @(negedge clk); rst_n = 1'b1; pkt_ready = 1'b1;
    idle(1);
    send_byte(8'h5A, 1'b1);
    idle(3);
    chk("t6_nq", popq.size(), 1);
    chk_q("t6_w0", 0, 9'h15A);
    chk("t6_ferr", frame_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/router_out_deserializer.md
Name: router_out_deserializer

Overview:
- Per-port receiver placed directly downstream of a router output port.
- Consumes the router's serial output stream (dout, valido_n, frameo_n), rebuilds payload bytes LSB-first and buffers them in a small FIFO.
- Presents bytes on a ready/valid interface with an end-of-packet marker, for use by scoreboards, monitors and the egress logic of the next hop.

Parameters:
- DATA_W, 8: payload word width in bits; serial bits per word.
- FIFO_DEPTH, 4: word entries in the output FIFO; power of two, minimum 2.

Ports:
- clock  in  1  rising-edge clock, shared with the router.
- reset_n  in  1  asynchronous active-low reset.
- dout  in  1  serial payload bit from the router output port.
- valido_n  in  1  active-low; dout carries a valid bit this cycle.
- frameo_n  in  1  active-low frame; rises together with the last valid bit.
- pkt_data  out  DATA_W  head-of-FIFO word.
- pkt_last  out  1  head word is the final word of its packet.
- pkt_valid  out  1  FIFO non-empty.
- pkt_ready  in  1  consumer accepts the head word when pkt_valid && pkt_ready.
- rx_busy  out  1  a frame is being received (FSM in RECV).
- frame_err  out  1  sticky: frame ended with a partial word.
- ovf_err  out  1  sticky: completed word dropped because the FIFO was full.
- clr_err  in  1  synchronous clear of frame_err and ovf_err.

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE, bit counter=0, shift register=0, FIFO empty.
  - Outputs: pkt_valid=0, pkt_data=0, pkt_last=0, rx_busy=0, frame_err=0, ovf_err=0.
  - Reset mid-frame discards the partial word and all FIFO contents.
- All inputs are sampled at posedge clock. A bit is taken only when valido_n=0.
- FSM, IDLE:
  - frameo_n=1: stay in IDLE; bits with valido_n=0 are ignored.
  - frameo_n=0: go to RECV. If valido_n=0 in the same cycle, that bit is captured as bit 0.
- FSM, RECV:
  - valido_n=0: shift dout into bit position [count]; count++.
  - Word completion: the edge that samples bit DATA_W-1 pushes {dout, shreg[DATA_W-2:0]} into the FIFO and resets count to 0. pkt_last is set if frameo_n=1 on that same sample.
  - valido_n=0 with frameo_n=1 (last bit): go to IDLE after the shift. If count after the shift is not 0 (mod DATA_W), set frame_err and drop the partial word.
  - valido_n=1 with frameo_n=1: protocol abort. Go to IDLE; set frame_err if count≠0; the partial word is dropped.
  - The frame completing in cycle N and a new frameo_n=0 in cycle N+1 is accepted (back-to-back frames).
- Latency: pkt_valid=1 on the first cycle after the edge that sampled the word's last bit. The FIFO does not bypass, even when empty.
- FIFO:
  - Pop when pkt_valid && pkt_ready.
  - When full, a push in the same cycle as a pop is accepted.
  - When full with no pop, the completed word is dropped and ovf_err is set; FSM and bit counting are unaffected.
  - Pointers wrap modulo FIFO_DEPTH; a count register of width log2(FIFO_DEPTH)+1 distinguishes full from empty.
  - pkt_data and pkt_last are the head entry while pkt_valid=1, and 0 when empty.
- Errors:
  - clr_err clears both error flags.
  - A set event in the same cycle as clr_err wins (flag stays 1).

Optional Feature:
- ROUTER_DESER_PKTCNT_EN.
- Defined: adds output ports pkt_cnt[15:0] and word_cnt[15:0].
  - pkt_cnt increments on each pop with pkt_last=1.
  - word_cnt increments on each pop.
  - Both wrap at 16 bits, reset to 0, and clear on clr_err.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package router_pkg:
  - enum rx_state_e {RX_IDLE, RX_RECV}.
  - Localparam PORT_NUM=16.
  - Typedef rx_word_t struct {logic [DATA_W-1:0] data; logic last;}.
- Sub-module router_out_fifo: a synchronous FIFO parameterized on entry type and depth, instantiated once.

Test Plan:
- Single 2-byte packet 8'hA5, 8'h3C sent LSB-first, frameo_n rising with the 16th bit, pkt_ready=1 -> two pops: A5/last=0 then 3C/last=1; pkt_valid rises one cycle after the 8th bit; frame_err=0.
- Gaps: valido_n=1 for 3 cycles between bits 3 and 4 of byte 8'h81 -> byte still 8'h81; rx_busy=1 throughout the gaps.
- Partial word: frame ends after 12 valid bits -> one word pushed; frame_err=1; clr_err pulse -> frame_err=0.
- Overflow: FIFO_DEPTH=4, pkt_ready=0, 5-byte packet -> 4 words held, ovf_err=1. With pkt_ready=1 -> words 0..3 pop in order and the 5th is lost.
- Back-to-back packets 1 byte 8'hFF and 1 byte 8'h00, frameo_n low again the cycle after it rises -> FF/last=1 then 00/last=1.
- Async reset asserted mid-byte with 2 words queued -> pkt_valid=0 immediately. After release, a fresh packet 8'h5A is received correctly.
